// File: rtl/axi_pkg.sv
// Shared AXI response codes, slave FSM states and arbiter grant encoding.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, W_DATA, W_RESP, R_DATA} ram_state_t;
  typedef enum logic {WRITE, READ} grant_t;

endpackage

// File: rtl/axi_if.sv
// AXI channel bundle: the subset of signals a simple INCR-burst memory slave consumes.
interface axi_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 4
) ();
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [STROBE_WIDTH-1:0] wstrb;
  logic                    wlast;
  logic [USER_WIDTH-1:0]   wuser;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic [USER_WIDTH-1:0]   buser;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [USER_WIDTH-1:0]   ruser;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wuser, wvalid, output wready,
    output bresp, buser, bvalid, input bready,
    input  araddr, arlen, arvalid, output arready,
    output rdata, rresp, rlast, ruser, rvalid, input rready
  );

  modport master (
    output awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wuser, wvalid, input wready,
    input  bresp, buser, bvalid, output bready,
    output araddr, arlen, arvalid, input arready,
    input  rdata, rresp, rlast, ruser, rvalid, output rready
  );
endinterface

// File: rtl/axi_ram_slave_ram_sp.sv
// Single-port RAM, one-cycle synchronous read, per-byte write enable, no reset.
module ram_sp #(
  parameter int  DEPTH      = 1024,
  parameter int  DATA_WIDTH = 32,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_en,
  input  logic [DATA_WIDTH/8-1:0] i_we,
  input  logic [AW-1:0]           i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Read data only updates on a pure read, so it doubles as the R data holding register.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (|i_we) begin
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
          if (i_we[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/axi_ram_slave.sv
// AXI INCR-burst memory slave: write and read paths serialised by a round-robin
// arbiter in front of a single-port byte-writable RAM.
module axi_ram_slave #(
  parameter int DEPTH = 1024
) (
  input logic  clk,
  input logic  rst,
  axi_if.slave s_axi
);
  import axi_pkg::*;

  localparam int ADDR_WIDTH   = $bits(s_axi.awaddr);
  localparam int DATA_WIDTH   = $bits(s_axi.wdata);
  localparam int STROBE_WIDTH = $bits(s_axi.wstrb);
  localparam int USER_WIDTH   = $bits(s_axi.wuser);
  localparam int ADDR_LSB     = $clog2(STROBE_WIDTH);
  localparam int IDX_W        = $clog2(DEPTH);

  function automatic logic is_oor(input logic [ADDR_WIDTH-1:0] a);
    return |a[ADDR_WIDTH-1:ADDR_LSB+IDX_W];
  endfunction

  ram_state_t              r_state, w_state_d;
  grant_t                  r_last_grant;
  logic [IDX_W-1:0]        r_base, w_ram_addr;
  logic [7:0]              r_len;
  logic [8:0]              r_cnt;
  logic                    r_err;
  logic [1:0]              r_bresp, r_rresp;
  logic [USER_WIDTH-1:0]   r_buser;
  logic                    r_rvalid, r_rlast;
  logic                    w_awready, w_arready, w_wready, w_rd_issue, w_ram_en;
  logic [STROBE_WIDTH-1:0] w_ram_we;
  logic [DATA_WIDTH-1:0]   w_ram_rdata;
  logic                    w_aw_hs, w_ar_hs, w_w_hs, w_b_hs, w_r_hs, w_last_beat;

  assign w_aw_hs     = s_axi.awvalid & w_awready;
  assign w_ar_hs     = s_axi.arvalid & w_arready;
  assign w_w_hs      = s_axi.wvalid & w_wready;
  assign w_b_hs      = (r_state == W_RESP) & s_axi.bready;
  assign w_r_hs      = r_rvalid & s_axi.rready;
  assign w_last_beat = (r_cnt == {1'b0, r_len});
  assign w_ram_addr  = r_base + r_cnt[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_aw_hs)      w_state_d = W_DATA;
        else if (w_ar_hs) w_state_d = R_DATA;
      end
      W_DATA: if (w_w_hs && s_axi.wlast) w_state_d = W_RESP;
      W_RESP: if (w_b_hs) w_state_d = IDLE;
      R_DATA: if (w_r_hs && r_rlast) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    w_awready  = 1'b0;
    w_arready  = 1'b0;
    w_wready   = 1'b0;
    w_rd_issue = 1'b0;
    w_ram_en   = 1'b0;
    w_ram_we   = '0;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          // On a tie the path that lost last time wins.
          w_awready = s_axi.awvalid & (!s_axi.arvalid | (r_last_grant == READ));
          w_arready = !w_awready;
        end
        W_DATA: begin
          w_wready = 1'b1;
          w_ram_en = s_axi.wvalid & !r_err;
          w_ram_we = (s_axi.wvalid && !r_err) ? s_axi.wstrb : '0;
        end
        R_DATA: begin
          w_rd_issue = (r_cnt <= {1'b0, r_len}) & (!r_rvalid | s_axi.rready);
          w_ram_en   = w_rd_issue;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= READ;
      r_base       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_bresp      <= RESP_OKAY;
      r_buser      <= '0;
      r_rvalid     <= 1'b0;
      r_rlast      <= 1'b0;
      r_rresp      <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_last_grant <= WRITE;
        r_base       <= s_axi.awaddr[ADDR_LSB +: IDX_W];
        r_len        <= s_axi.awlen;
        r_err        <= is_oor(s_axi.awaddr);
        r_cnt        <= '0;
      end else if (w_ar_hs) begin
        r_last_grant <= READ;
        r_base       <= s_axi.araddr[ADDR_LSB +: IDX_W];
        r_len        <= s_axi.arlen;
        r_err        <= is_oor(s_axi.araddr);
        r_cnt        <= '0;
      end else if ((w_w_hs || w_rd_issue) && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 9'd1;
      end
      if (w_w_hs && s_axi.wlast) begin
        r_bresp <= (r_err || !w_last_beat) ? RESP_SLVERR : RESP_OKAY;
        r_buser <= s_axi.wuser;
      end
      if (w_rd_issue) begin
        r_rvalid <= 1'b1;
        r_rlast  <= w_last_beat;
        r_rresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  ram_sp #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk   (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (s_axi.wdata),
    .o_rdata (w_ram_rdata)
  );

  assign s_axi.awready = w_awready;
  assign s_axi.arready = w_arready;
  assign s_axi.wready  = w_wready;
  assign s_axi.bvalid  = (r_state == W_RESP) & !rst;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.buser   = r_buser;
  assign s_axi.rvalid  = r_rvalid & !rst;
  assign s_axi.rlast   = r_rlast;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rdata   = (r_rvalid && !r_err) ? w_ram_rdata : '0;
  assign s_axi.ruser   = '0;
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: vector table of single-beat transfers plus
// hand-written burst, backpressure, arbitration, error and reset sequences.
module tb_axi_ram_slave;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4), .USER_WIDTH(4)) axi ();

  axi_ram_slave #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (axi)
  );

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  wuser;
    logic [1:0]  exp_bresp;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t        tbl [7];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] gd [16];
  logic [1:0]  gr [16];
  logic        gl [16];
  int          n_got;
  logic [1:0]  b_resp;
  logic [3:0]  b_user;
  logic [31:0] exp_d [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len);
    int t = 0;
    axi.awaddr = addr; axi.awlen = len; axi.awvalid = 1'b1;
    @(negedge clk);
    while (!axi.awready && t < 50) begin t++; @(negedge clk); end
    chk("aw_handshake", axi.awready, 1);
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
  endtask

  task automatic w_phase(input int nb, input logic [3:0] user);
    for (int b = 0; b < nb; b++) begin
      int t = 0;
      axi.wdata = wd[b]; axi.wstrb = ws[b]; axi.wuser = user;
      axi.wlast = (b == nb - 1); axi.wvalid = 1'b1;
      @(negedge clk);
      if (b == 0) chk("w_ready_after_aw", axi.wready, 1);
      while (!axi.wready && t < 50) begin t++; @(negedge clk); end
      @(posedge clk); #1;
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
  endtask

  task automatic b_phase();
    int t = 0;
    axi.bready = 1'b1;
    @(negedge clk);
    chk("b_valid_next_cycle", axi.bvalid, 1);
    while (!axi.bvalid && t < 50) begin t++; @(negedge clk); end
    b_resp = axi.bresp; b_user = axi.buser;
    @(posedge clk); #1;
    axi.bready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int nb,
                          input logic [3:0] user);
    aw_phase(addr, len);
    w_phase(nb, user);
    b_phase();
  endtask

  task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len);
    int t = 0;
    axi.araddr = addr; axi.arlen = len; axi.arvalid = 1'b1;
    @(negedge clk);
    while (!axi.arready && t < 50) begin t++; @(negedge clk); end
    chk("ar_handshake", axi.arready, 1);
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
  endtask

  // Called right after the ar handshake edge; pat bit i drives rready in cycle i%4.
  task automatic r_collect(input int nbeats, input logic [3:0] pat);
    int          cyc = 0;
    int          first = -1;
    logic        stalled = 1'b0;
    logic [31:0] hd = '0;
    logic        hl = 1'b0;
    n_got = 0;
    while (n_got < nbeats && n_got < 16 && cyc < 200) begin
      cyc++;
      axi.rready = pat[(cyc - 1) % 4];
      @(negedge clk);
      if (stalled) begin
        chk("r_hold_valid", axi.rvalid, 1);
        chk("r_hold_data", axi.rdata, hd);
        chk("r_hold_last", axi.rlast, hl);
      end
      stalled = 1'b0;
      if (axi.rvalid) begin
        if (first < 0) first = cyc;
        if (axi.rready) begin
          gd[n_got] = axi.rdata; gr[n_got] = axi.rresp; gl[n_got] = axi.rlast;
          n_got++;
        end else begin
          stalled = 1'b1; hd = axi.rdata; hl = axi.rlast;
        end
      end
      @(posedge clk); #1;
    end
    axi.rready = 1'b0;
    chk("r_first_beat_latency", first, 2);
    chk("r_beat_count", n_got, nbeats);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] pat);
    ar_phase(addr, len);
    r_collect(int'(len) + 1, pat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h10,       32'hDEADBEEF, 4'hF, 4'd3, 2'b00, 32'h10, 32'hDEADBEEF, 2'b00};
    tbl[1] = '{32'h13,       32'h11223344, 4'h1, 4'd5, 2'b00, 32'h10, 32'hDEADBE44, 2'b00};
    tbl[2] = '{32'h3C,       32'hA5A5A5A5, 4'hF, 4'd1, 2'b00, 32'h3C, 32'hA5A5A5A5, 2'b00};
    tbl[3] = '{32'h3D,       32'h0000FF00, 4'h2, 4'd2, 2'b00, 32'h3C, 32'hA5A5FFA5, 2'b00};
    tbl[4] = '{32'h30,       32'hCAFEF00D, 4'hF, 4'd7, 2'b00, 32'h30, 32'hCAFEF00D, 2'b00};
    tbl[5] = '{32'hFFFFFFF0, 32'h00000000, 4'hF, 4'd4, 2'b10, 32'h30, 32'hCAFEF00D, 2'b00};
    tbl[6] = '{32'h40,       32'h12345678, 4'hF, 4'd6, 2'b10, 32'h40, 32'h00000000, 2'b10};

    axi.awaddr = '0; axi.awlen = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wuser = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arlen = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_ready_valid", {axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid}, 5'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_arready", axi.arready, 1);
    chk("idle_awready_no_req", axi.awready, 0);
    chk("idle_wready", axi.wready, 0);
    chk("idle_bvalid", axi.bvalid, 0);
    chk("idle_rvalid", axi.rvalid, 0);
    @(posedge clk); #1;

    // Single-beat vectors
    for (int i = 0; i < 7; i++) begin
      wd[0] = tbl[i].wdata; ws[0] = tbl[i].wstrb;
      do_write(tbl[i].waddr, 8'd0, 1, tbl[i].wuser);
      chk($sformatf("vec%0d_bresp", i), b_resp, tbl[i].exp_bresp);
      chk($sformatf("vec%0d_buser", i), b_user, tbl[i].wuser);
      do_read(tbl[i].raddr, 8'd0, 4'b1111);
      chk($sformatf("vec%0d_rdata", i), gd[0], tbl[i].exp_rdata);
      chk($sformatf("vec%0d_rresp", i), gr[0], tbl[i].exp_rresp);
      chk($sformatf("vec%0d_rlast", i), gl[0], 1);
    end

    // Strobed burst wrapping from word 14 to word 1
    for (int k = 0; k < 4; k++) begin wd[k] = 32'h55555555; ws[k] = 4'hF; end
    do_write(32'h38, 8'd3, 4, 4'd0);
    chk("wrap_prefill_bresp", b_resp, 2'b00);
    wd[0] = 32'h14141414; wd[1] = 32'h15151515; wd[2] = 32'hA0A0A0A0; wd[3] = 32'hA1A1A1A1;
    ws[1] = 4'h3;
    do_write(32'h38, 8'd3, 4, 4'd0);
    chk("wrap_bresp", b_resp, 2'b00);
    exp_d[0] = 32'h14141414; exp_d[1] = 32'h55551515;
    exp_d[2] = 32'hA0A0A0A0; exp_d[3] = 32'hA1A1A1A1;
    do_read(32'h38, 8'd3, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap_rdata%0d", k), gd[k], exp_d[k]);
      chk($sformatf("wrap_rlast%0d", k), gl[k], k == 3);
    end
    do_read(32'h00, 8'd0, 4'b1111);
    chk("wrap_word0", gd[0], 32'hA0A0A0A0);

    // 8-beat read under rready 1,0,0,1 backpressure
    for (int k = 0; k < 8; k++) begin
      wd[k] = 32'h10000000 + 32'h11 * k; ws[k] = 4'hF;
    end
    do_write(32'h00, 8'd7, 8, 4'd0);
    chk("bp_bresp", b_resp, 2'b00);
    do_read(32'h00, 8'd7, 4'b1001);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("bp_rdata%0d", k), gd[k], 32'h10000000 + 32'h11 * k);
      chk($sformatf("bp_rlast%0d", k), gl[k], k == 7);
    end

    // Early wlast: len 3 burst ending on beat 1
    wd[0] = 32'h77777777; wd[1] = 32'h88888888; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'h20, 8'd3, 2, 4'd9);
    chk("short_burst_bresp", b_resp, 2'b10);
    chk("short_burst_buser", b_user, 4'd9);
    do_read(32'h20, 8'd1, 4'b1111);
    chk("short_burst_word0", gd[0], 32'h77777777);
    chk("short_burst_word1", gd[1], 32'h88888888);

    // Out-of-range read burst
    do_read(32'h100, 8'd2, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("oor_rdata%0d", k), gd[k], 32'h0);
      chk($sformatf("oor_rresp%0d", k), gr[k], 2'b10);
      chk($sformatf("oor_rlast%0d", k), gl[k], k == 2);
    end

    // Arbitration: three back-to-back ties after a read
    axi.araddr = 32'h28; axi.arlen = 8'd0; axi.arvalid = 1'b1;
    axi.awaddr = 32'h28; axi.awlen = 8'd0; axi.awvalid = 1'b1;
    @(negedge clk);
    chk("tie1_awready", axi.awready, 1);
    chk("tie1_arready", axi.arready, 0);
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    wd[0] = 32'h0A0A0A0A; ws[0] = 4'hF;
    w_phase(1, 4'd0);
    b_phase();
    chk("tie1_bresp", b_resp, 2'b00);
    axi.awaddr = 32'h2C; axi.awvalid = 1'b1;
    @(negedge clk);
    chk("tie2_arready", axi.arready, 1);
    chk("tie2_awready", axi.awready, 0);
    @(posedge clk); #1;
    axi.arvalid = 1'b0; axi.awvalid = 1'b0;
    r_collect(1, 4'b1111);
    chk("tie2_read_after_write", gd[0], 32'h0A0A0A0A);
    axi.araddr = 32'h2C; axi.arvalid = 1'b1;
    axi.awaddr = 32'h2C; axi.awvalid = 1'b1;
    @(negedge clk);
    chk("tie3_awready", axi.awready, 1);
    chk("tie3_arready", axi.arready, 0);
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    wd[0] = 32'h0B0B0B0B;
    w_phase(1, 4'd0);
    b_phase();
    ar_phase(32'h2C, 8'd0);
    r_collect(1, 4'b1111);
    chk("tie3_rdata", gd[0], 32'h0B0B0B0B);

    // Reset during beat 2 of a 4-beat write
    aw_phase(32'h20, 8'd3);
    for (int b = 0; b < 2; b++) begin
      axi.wdata = 32'hC0C0C0C0 + b; axi.wstrb = 4'hF; axi.wlast = 1'b0; axi.wvalid = 1'b1;
      @(negedge clk);
      chk($sformatf("rst_seq_wready%0d", b), axi.wready, 1);
      @(posedge clk); #1;
    end
    axi.wdata = 32'hC0C0C0C2; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_burst_ready_valid",
        {axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid}, 5'b0);
    @(posedge clk); #1;
    rst = 1'b0; axi.wvalid = 1'b0;
    axi.awaddr = 32'h24; axi.awlen = 8'd0; axi.awvalid = 1'b1;
    @(negedge clk);
    chk("post_reset_awready", axi.awready, 1);
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    wd[0] = 32'h5A5A5A5A; ws[0] = 4'hF;
    w_phase(1, 4'd2);
    b_phase();
    chk("post_reset_bresp", b_resp, 2'b00);
    chk("post_reset_buser", b_user, 4'd2);
    do_read(32'h24, 8'd0, 4'b1111);
    chk("post_reset_rdata", gd[0], 32'h5A5A5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
